// File: rtl/ft60x_defs.sv
// Shared constants and word layout for the FT60x device emulator.
// Each FIFO word carries the byte enables above the 32-bit data.
package ft60x_defs;

    localparam int FT_DATA_W          = 32;
    localparam int FT_BE_W            = 4;
    localparam int FT_WORD_W          = FT_DATA_W + FT_BE_W;
    localparam int FT_DEPTH_LOG2_DEF  = 4;

    typedef struct packed {
        logic [FT_BE_W-1:0]   be;
        logic [FT_DATA_W-1:0] data;
    } ft_word_t;

endpackage

// File: rtl/ft60x_emu_fifo.sv
// Synchronous first-word-fall-through FIFO; head_o always shows the oldest word.
// Level is one bit wider than the pointers so full and empty are distinct.
module ft60x_emu_fifo #(
    parameter int WIDTH      = 36,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      push_data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      head_o,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  full_o,
    output logic                  empty_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   level;
    logic                  push_ok;
    logic                  pop_ok;

    // A full FIFO never accepts a push, even if a pop frees a slot on the same edge.
    assign full_o  = (level == FULL_LVL);
    assign empty_o = (level == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign head_o  = mem[rd_ptr];
    assign level_o = level;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok && !rst_i) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/ft60x_dev_emu.sv
// Device end of the FT60x 245 synchronous FIFO bus, with host streams that load
// the RX FIFO and drain the TX FIFO, plus saturating protocol-violation counters.
module ft60x_dev_emu
    import ft60x_defs::*;
#(
    parameter int DEPTH_LOG2 = FT_DEPTH_LOG2_DEF,
    parameter int ERR_W      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  ftdi_rxf_n_o,
    output logic                  ftdi_txe_n_o,
    input  logic                  ftdi_oen_i,
    input  logic                  ftdi_rdn_i,
    input  logic                  ftdi_wrn_i,
    output logic [FT_DATA_W-1:0]  ftdi_data_o,
    output logic [FT_BE_W-1:0]    ftdi_be_o,
    output logic                  ftdi_data_oe_o,
    input  logic [FT_DATA_W-1:0]  ftdi_data_i,
    input  logic [FT_BE_W-1:0]    ftdi_be_i,
    input  logic                  inj_valid_i,
    input  logic [FT_DATA_W-1:0]  inj_data_i,
    input  logic [FT_BE_W-1:0]    inj_be_i,
    output logic                  inj_ready_o,
    output logic                  cap_valid_o,
    output logic [FT_DATA_W-1:0]  cap_data_o,
    output logic [FT_BE_W-1:0]    cap_be_o,
    input  logic                  cap_ready_i,
    output logic [DEPTH_LOG2:0]   rx_level_o,
    output logic [DEPTH_LOG2:0]   tx_level_o,
    output logic [ERR_W-1:0]      underrun_cnt_o,
    output logic [ERR_W-1:0]      overrun_cnt_o
);

    ft_word_t          rx_head;
    ft_word_t          tx_head;
    logic              rx_full;
    logic              rx_empty;
    logic              tx_full;
    logic              tx_empty;
    logic              rx_push;
    logic              rx_pop;
    logic              tx_push;
    logic              tx_pop;
    logic              underrun;
    logic              overrun;
    logic [ERR_W-1:0]  underrun_cnt;
    logic [ERR_W-1:0]  overrun_cnt;

    // Bus flags come only from the registered levels, never from this cycle's strobes.
    assign ftdi_rxf_n_o   = rx_empty;
    assign ftdi_txe_n_o   = tx_full;
    assign ftdi_data_oe_o = ~ftdi_oen_i;

    assign rx_pop   = !ftdi_oen_i && !ftdi_rdn_i && !ftdi_rxf_n_o;
    assign underrun = !ftdi_rdn_i && ftdi_rxf_n_o;
    assign tx_push  = !ftdi_wrn_i && !ftdi_txe_n_o;
    assign overrun  = !ftdi_wrn_i && ftdi_txe_n_o;

    assign inj_ready_o = !rx_full;
    assign rx_push     = inj_valid_i && inj_ready_o;
    assign cap_valid_o = !tx_empty;
    assign tx_pop      = cap_valid_o && cap_ready_i;

    always_comb begin
        ftdi_data_o = '0;
        ftdi_be_o   = '0;
        cap_data_o  = '0;
        cap_be_o    = '0;
        if (!ftdi_oen_i && !rx_empty) begin
            ftdi_data_o = rx_head.data;
            ftdi_be_o   = rx_head.be;
        end
        if (cap_valid_o) begin
            cap_data_o = tx_head.data;
            cap_be_o   = tx_head.be;
        end
    end

    ft60x_emu_fifo #(
        .WIDTH      (FT_WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_rx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (rx_push),
        .push_data_i ({inj_be_i, inj_data_i}),
        .pop_i       (rx_pop),
        .head_o      (rx_head),
        .level_o     (rx_level_o),
        .full_o      (rx_full),
        .empty_o     (rx_empty)
    );

    ft60x_emu_fifo #(
        .WIDTH      (FT_WORD_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_tx_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (tx_push),
        .push_data_i ({ftdi_be_i, ftdi_data_i}),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .level_o     (tx_level_o),
        .full_o      (tx_full),
        .empty_o     (tx_empty)
    );

    // Violation counters stick at all-ones rather than wrapping back to zero.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            underrun_cnt <= '0;
            overrun_cnt  <= '0;
        end else begin
            if (underrun && (underrun_cnt != '1)) underrun_cnt <= underrun_cnt + ERR_W'(1);
            if (overrun && (overrun_cnt != '1))   overrun_cnt  <= overrun_cnt + ERR_W'(1);
        end
    end

    assign underrun_cnt_o = underrun_cnt;
    assign overrun_cnt_o  = overrun_cnt;

endmodule

// File: tb/tb_ft60x_dev_emu.sv
// Directed bench for ft60x_dev_emu: bridge reads/writes, host inject/capture,
// error counters (including a 2-bit counter instance), full/wrap and mid-burst reset.
module tb_ft60x_dev_emu;

    logic        clk = 1'b0;
    logic        rst;
    logic        oen, rdn, wrn;
    logic [31:0] data_i;
    logic [3:0]  be_i;
    logic        inj_valid;
    logic [31:0] inj_data;
    logic [3:0]  inj_be;
    logic        cap_ready;

    logic        rxf_n, txe_n, data_oe, inj_ready, cap_valid;
    logic [31:0] data_o, cap_data;
    logic [3:0]  be_o, cap_be;
    logic [4:0]  rx_level, tx_level;
    logic [7:0]  underrun_cnt, overrun_cnt;

    logic        d2_rxf_n, d2_txe_n, d2_data_oe, d2_inj_ready, d2_cap_valid;
    logic [31:0] d2_data_o, d2_cap_data;
    logic [3:0]  d2_be_o, d2_cap_be;
    logic [4:0]  d2_rx_level, d2_tx_level;
    logic [1:0]  d2_underrun_cnt, d2_overrun_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ft60x_dev_emu #(.DEPTH_LOG2(4), .ERR_W(8)) dut (
        .clk_i(clk), .rst_i(rst),
        .ftdi_rxf_n_o(rxf_n), .ftdi_txe_n_o(txe_n),
        .ftdi_oen_i(oen), .ftdi_rdn_i(rdn), .ftdi_wrn_i(wrn),
        .ftdi_data_o(data_o), .ftdi_be_o(be_o), .ftdi_data_oe_o(data_oe),
        .ftdi_data_i(data_i), .ftdi_be_i(be_i),
        .inj_valid_i(inj_valid), .inj_data_i(inj_data), .inj_be_i(inj_be), .inj_ready_o(inj_ready),
        .cap_valid_o(cap_valid), .cap_data_o(cap_data), .cap_be_o(cap_be), .cap_ready_i(cap_ready),
        .rx_level_o(rx_level), .tx_level_o(tx_level),
        .underrun_cnt_o(underrun_cnt), .overrun_cnt_o(overrun_cnt)
    );

    ft60x_dev_emu #(.DEPTH_LOG2(4), .ERR_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst),
        .ftdi_rxf_n_o(d2_rxf_n), .ftdi_txe_n_o(d2_txe_n),
        .ftdi_oen_i(oen), .ftdi_rdn_i(rdn), .ftdi_wrn_i(wrn),
        .ftdi_data_o(d2_data_o), .ftdi_be_o(d2_be_o), .ftdi_data_oe_o(d2_data_oe),
        .ftdi_data_i(data_i), .ftdi_be_i(be_i),
        .inj_valid_i(inj_valid), .inj_data_i(inj_data), .inj_be_i(inj_be), .inj_ready_o(d2_inj_ready),
        .cap_valid_o(d2_cap_valid), .cap_data_o(d2_cap_data), .cap_be_o(d2_cap_be), .cap_ready_i(cap_ready),
        .rx_level_o(d2_rx_level), .tx_level_o(d2_tx_level),
        .underrun_cnt_o(d2_underrun_cnt), .overrun_cnt_o(d2_overrun_cnt)
    );

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input logic o, input logic r, input logic w,
                                 input logic iv, input logic cr);
        oen       = o;
        rdn       = r;
        wrn       = w;
        inj_valid = iv;
        cap_ready = cr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst = 1'b1; data_i = '0; be_i = '0; inj_data = '0; inj_be = '0;
        applyStimulus(1, 1, 1, 0, 0);
        step(); step();
        rst = 1'b0;
        #1;

        checkOutput("rst_rx_level", rx_level, 0);
        checkOutput("rst_tx_level", tx_level, 0);
        checkOutput("rst_rxf_n", rxf_n, 1);
        checkOutput("rst_txe_n", txe_n, 0);
        checkOutput("rst_inj_ready", inj_ready, 1);
        checkOutput("rst_cap_valid", cap_valid, 0);
        checkOutput("rst_data_o", data_o, 0);
        checkOutput("rst_cap_data", cap_data, 0);
        checkOutput("rst_underrun", underrun_cnt, 0);
        checkOutput("rst_overrun", overrun_cnt, 0);
        checkOutput("rst_data_oe", data_oe, 0);

        // Four injected words read back as one RD burst
        for (int i = 0; i < 4; i++) begin
            inj_data = 32'h1111_1111 * (i + 1);
            inj_be   = 4'hF;
            applyStimulus(1, 1, 1, 1, 0);
            step();
        end
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("burst_level", rx_level, 4);
        checkOutput("burst_rxf_n", rxf_n, 0);
        checkOutput("burst_data_oe", data_oe, 1);
        applyStimulus(0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            checkOutput("burst_data", data_o, 32'h1111_1111 * (i + 1));
            checkOutput("burst_be", be_o, 4'hF);
            step();
        end
        checkOutput("burst_rxf_n_rise", rxf_n, 1);
        checkOutput("burst_data_empty", data_o, 0);
        checkOutput("burst_underrun", underrun_cnt, 0);
        applyStimulus(1, 1, 1, 0, 0);

        // RD against an empty RX FIFO
        applyStimulus(0, 0, 1, 0, 0);
        step(); step(); step();
        checkOutput("under_cnt3", underrun_cnt, 3);
        checkOutput("under_data", data_o, 0);
        step(); step();
        checkOutput("under_cnt5", underrun_cnt, 5);
        checkOutput("under_sat_w2", d2_underrun_cnt, 3);
        applyStimulus(1, 1, 1, 0, 0);

        // 17 bridge writes into a 16-deep TX FIFO, then drain
        for (int i = 0; i < 16; i++) begin
            data_i = 32'h100 + i;
            be_i   = 4'hF;
            applyStimulus(1, 1, 0, 0, 0);
            step();
        end
        checkOutput("tx_full_txe_n", txe_n, 1);
        data_i = 32'h110;
        step();
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("tx_level16", tx_level, 16);
        checkOutput("tx_overrun", overrun_cnt, 1);
        applyStimulus(1, 1, 1, 0, 1);
        for (int i = 0; i < 16; i++) begin
            checkOutput("cap_valid", cap_valid, 1);
            checkOutput("cap_data", cap_data, 32'h100 + i);
            checkOutput("cap_be", cap_be, 4'hF);
            step();
        end
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("cap_empty", cap_valid, 0);
        checkOutput("cap_data_empty", cap_data, 0);
        checkOutput("tx_txe_n_low", txe_n, 0);

        // Full RX FIFO: host push and bridge pop on the same edge
        for (int i = 0; i < 16; i++) begin
            inj_data = 32'h200 + i;
            inj_be   = 4'hF;
            applyStimulus(1, 1, 1, 1, 0);
            step();
        end
        inj_data = 32'hDEAD_BEEF;
        applyStimulus(0, 0, 1, 1, 0);
        checkOutput("full_level16", rx_level, 16);
        checkOutput("full_inj_ready", inj_ready, 0);
        step();
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("full_level15", rx_level, 15);
        for (int i = 1; i < 16; i++) begin
            checkOutput("full_drain", data_o, 32'h200 + i);
            step();
        end
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("full_drained", rx_level, 0);

        // Reset in the middle of a burst
        for (int i = 0; i < 8; i++) begin
            inj_data = 32'h500 + i;
            applyStimulus(1, 1, 1, 1, 0);
            step();
        end
        applyStimulus(0, 0, 1, 0, 0);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("mrst_level", rx_level, 0);
        checkOutput("mrst_rxf_n", rxf_n, 1);
        checkOutput("mrst_underrun", underrun_cnt, 0);
        checkOutput("mrst_overrun", overrun_cnt, 0);
        inj_data = 32'hCAFE_F00D;
        inj_be   = 4'hF;
        applyStimulus(1, 1, 1, 1, 0);
        step();
        applyStimulus(0, 1, 1, 0, 0);
        checkOutput("mrst_level1", rx_level, 1);
        checkOutput("mrst_word", data_o, 32'hCAFE_F00D);
        applyStimulus(0, 0, 1, 0, 0);
        step();
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("mrst_after_pop", rx_level, 0);

        // 24 words streamed through, wrapping the pointers
        inj_data = 32'h3000_0000;
        inj_be   = 4'b0011;
        applyStimulus(1, 1, 1, 1, 0);
        step();
        for (int i = 1; i < 24; i++) begin
            inj_data = 32'h3000_0000 + i;
            applyStimulus(0, 0, 1, 1, 0);
            checkOutput("wrap_data", data_o, 32'h3000_0000 + i - 1);
            checkOutput("wrap_be", be_o, 4'b0011);
            step();
        end
        applyStimulus(0, 0, 1, 0, 0);
        checkOutput("wrap_last", data_o, 32'h3000_0017);
        step();
        applyStimulus(1, 1, 1, 0, 0);
        checkOutput("wrap_level", rx_level, 0);
        checkOutput("wrap_underrun", underrun_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ft60x_dev_emu.md
FT60X_DEV_EMU -- requirements
Module: ft60x_dev_emu

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, giving each FIFO a depth of 2**DEPTH_LOG2 words.
REQ-002 SHALL have parameter ERR_W, default 8, giving the width of each error counter.
REQ-003 clk_i  in  1  single clock; the FT60x bus and the host side are both synchronous to it.
REQ-004 rst_i  in  1  synchronous, active-high reset.
REQ-005 ftdi_rxf_n_o  out  1  low = the device holds data for the bridge to read.
REQ-006 ftdi_txe_n_o  out  1  low = the device can accept a write from the bridge.
REQ-007 ftdi_oen_i  in  1  bridge output-enable request, active low.
REQ-008 ftdi_rdn_i  in  1  bridge read strobe, active low.
REQ-009 ftdi_wrn_i  in  1  bridge write strobe, active low.
REQ-010 ftdi_data_o / ftdi_be_o  out  32/4  device-to-bridge word and byte enables.
REQ-011 ftdi_data_oe_o  out  1  high = the device drives the shared DATA/BE bus.
REQ-012 ftdi_data_i / ftdi_be_i  in  32/4  bridge-to-device word and byte enables.
REQ-013 inj_valid_i, inj_data_i[31:0], inj_be_i[3:0] in; inj_ready_o out  host stream that loads the RX FIFO.
REQ-014 cap_valid_o, cap_data_o[31:0], cap_be_o[3:0] out; cap_ready_i in  host stream that drains the TX FIFO.
REQ-015 rx_level_o / tx_level_o  out  DEPTH_LOG2+1  fill level of each FIFO.
REQ-016 underrun_cnt_o / overrun_cnt_o  out  ERR_W  protocol-violation counters.

Function
REQ-017 SHALL act as the device end of the FT60x 245 synchronous FIFO bus, so that the ft60x_axi bridge is the initiator.
REQ-018 ftdi_rxf_n_o SHALL equal (rx_level_o==0), derived from the registered count only; it reflects a pop in the cycle after the pop.
REQ-019 ftdi_txe_n_o SHALL equal (tx_level_o==2**DEPTH_LOG2), derived from the registered count only.
REQ-020 ftdi_data_oe_o SHALL equal ~ftdi_oen_i.
REQ-021 ftdi_data_o/ftdi_be_o SHALL show the RX FIFO head whenever ftdi_oen_i is low and the RX FIFO is non-empty; otherwise they SHALL be 0.
REQ-022 An RX pop SHALL occur on every clock edge where ftdi_oen_i=0, ftdi_rdn_i=0 and ftdi_rxf_n_o=0; consecutive strobe cycles pop consecutive words (burst, one word per clock).
REQ-023 A TX push of {ftdi_be_i, ftdi_data_i} SHALL occur on every edge where ftdi_wrn_i=0 and ftdi_txe_n_o=0.
REQ-024 If ftdi_rdn_i=0 while ftdi_rxf_n_o=1, the device SHALL not pop and SHALL increment underrun_cnt_o once per such cycle.
REQ-025 If ftdi_wrn_i=0 while ftdi_txe_n_o=1, the device SHALL drop the word and SHALL increment overrun_cnt_o once per such cycle.
REQ-026 Both error counters SHALL saturate at all-ones.
REQ-027 inj_ready_o SHALL equal "RX FIFO not full"; a push occurs on valid&&ready.
REQ-028 A push and a pop in the same cycle SHALL leave the level unchanged.
REQ-029 A push into a full FIFO SHALL never occur, even when a pop happens in the same cycle.
REQ-030 cap_valid_o SHALL equal "TX FIFO not empty"; cap_data_o/cap_be_o SHALL show the head word; a pop occurs on valid&&ready.
REQ-031 FIFO pointers SHALL be DEPTH_LOG2 bits and wrap modulo the depth; the levels SHALL be DEPTH_LOG2+1 bits so that full is distinct from empty.
REQ-032 Words SHALL pass through each FIFO in order and unmodified, including BE values such as 4'b0001.

Reset
REQ-033 While rst_i is high, both FIFOs SHALL flush: levels 0, pointers 0, counters 0, rxf_n_o=1, txe_n_o=0, inj_ready_o=1, cap_valid_o=0, data/be outputs 0.
REQ-034 A reset asserted mid-burst SHALL discard all in-flight words, and no pop or push SHALL be recorded on that edge.

Structure
REQ-035 The shared package ft60x_defs SHALL hold FT_DATA_W=32, FT_BE_W=4 and the default depth constant.
REQ-036 The design SHALL contain one sub-module, ft60x_emu_fifo (synchronous FIFO, first-word-fall-through, parameterised width/depth), instantiated twice with width 36.

Verification
REQ-037 Inject 0x11111111..0x44444444 with BE=4'hF; bridge asserts OE then RD for 4 clocks -> data_o shows the 4 words in order, rxf_n_o rises the cycle after the 4th pop, underrun_cnt=0.
REQ-038 Bridge writes 17 words (0x100+i) with cap_ready_i=0, DEPTH_LOG2=4 -> txe_n_o high after 16 words, overrun_cnt=1; then cap_ready_i=1 -> 0x100..0x10F drained in order.
REQ-039 RD held low for 3 cycles with an empty RX FIFO -> underrun_cnt=3 and data_o=0; with ERR_W=2 and 5 such cycles -> counter stays at 3.
REQ-040 RX FIFO full (16 words): host pushes while the bridge pops in the same cycle -> inj_ready_o=0 on that cycle, the push is not taken, level drops to 15.
REQ-041 rst_i pulsed for 1 cycle mid-burst with 8 words queued -> next cycle rx_level=0, rxf_n_o=1, counters=0, and the subsequent inject/read of 0xCAFEF00D returns exactly that word.
REQ-042 Inject 24 words while draining continuously -> pointers wrap and the sequence is intact, with BE 4'b0011 preserved.
